// File: rtl/regfile_pkg.sv
// Shared types for the write-back path: the two-lane write bundle seen by the
// write buffer, the register file and the bench.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic                  we1;
        logic [REG_ADDR_W-1:0] reg1;
        logic [DATA_W-1:0]     data1;
        logic                  we2;
        logic [REG_ADDR_W-1:0] reg2;
        logic [DATA_W-1:0]     data2;
    } wb_bundle_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Circular bundle store with push/pop, occupancy count and all slots exposed
// so the owner can run an age-ordered bypass search.
module regfile_wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  wb_bundle_t             i_data,
    output wb_bundle_t             o_head,
    output logic [PW:0]            o_count,
    output logic [PW-1:0]          o_rd_ptr,
    output wb_bundle_t [DEPTH-1:0] o_entries
);

    wb_bundle_t [DEPTH-1:0] r_mem;
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW:0]            r_count;
    logic                   w_pop;

    // Pointers are exactly PW bits wide, so wrap modulo DEPTH falls out for free
    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_entries = r_mem;

endmodule

// File: rtl/regfile_write_buffer.sv
// Write-back staging buffer ahead of the dual-write register file: normalises
// bundles on entry, drains one per cycle and offers a bypass lookup.
module regfile_write_buffer
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter bit ZERO_REG = 1'b1,
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic                  InWe1,
    input  logic                  InWe2,
    input  logic [REG_ADDR_W-1:0] InReg1,
    input  logic [REG_ADDR_W-1:0] InReg2,
    input  logic [DATA_W-1:0]     InData1,
    input  logic [DATA_W-1:0]     InData2,
    input  logic                  Stall,
    output logic [REG_ADDR_W-1:0] WriteRegister1,
    output logic [REG_ADDR_W-1:0] WriteRegister2,
    output logic [DATA_W-1:0]     WriteData1,
    output logic [DATA_W-1:0]     WriteData2,
    output logic                  RegWrite1,
    output logic                  RegWrite2,
    input  logic [REG_ADDR_W-1:0] LookupReg1,
    input  logic [REG_ADDR_W-1:0] LookupReg2,
    output logic                  Hit1,
    output logic                  Hit2,
    output logic [DATA_W-1:0]     HitData1,
    output logic [DATA_W-1:0]     HitData2,
    output logic [PW:0]           Count,
    output logic [7:0]            CollisionCount
);

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    wb_bundle_t             w_in;
    wb_bundle_t             w_head;
    wb_bundle_t             w_outs;
    wb_bundle_t [DEPTH-1:0] w_entries;
    logic [PW-1:0]          w_rd_ptr;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_collide;
    logic [7:0]             r_coll_cnt;

    // Zero-register drop first, so a pair of reg-0 writes is not a collision
    always_comb begin
        w_in = {InWe1, InReg1, InData1, InWe2, InReg2, InData2};
        if (ZERO_REG && InReg1 == '0) w_in.we1 = 1'b0;
        if (ZERO_REG && InReg2 == '0) w_in.we2 = 1'b0;
        w_collide = w_in.we1 && w_in.we2 && (InReg1 == InReg2);
        if (w_collide) w_in.we1 = 1'b0;
    end

    assign InReady = (Count != FULL_CNT);
    assign w_push  = InValid && InReady;
    assign w_pop   = (Count != '0) && !Stall;

    regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (Clk),
        .rst       (Reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (w_in),
        .o_head    (w_head),
        .o_count   (Count),
        .o_rd_ptr  (w_rd_ptr),
        .o_entries (w_entries)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RegWrite1      <= 1'b0;
            RegWrite2      <= 1'b0;
            WriteRegister1 <= '0;
            WriteRegister2 <= '0;
            WriteData1     <= '0;
            WriteData2     <= '0;
        end else if (w_pop) begin
            RegWrite1      <= w_head.we1;
            RegWrite2      <= w_head.we2;
            WriteRegister1 <= w_head.reg1;
            WriteRegister2 <= w_head.reg2;
            WriteData1     <= w_head.data1;
            WriteData2     <= w_head.data2;
        end else begin
            RegWrite1 <= 1'b0;
            RegWrite2 <= 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                                       r_coll_cnt <= '0;
        else if (w_push && w_collide && r_coll_cnt != 8'hFF) r_coll_cnt <= r_coll_cnt + 8'd1;
    end
    assign CollisionCount = r_coll_cnt;

    assign w_outs = {RegWrite1, WriteRegister1, WriteData1, RegWrite2, WriteRegister2, WriteData2};

    // Walk oldest to newest (output stage first); later matches override earlier ones
    function automatic logic [DATA_W:0] f_lookup(
        input logic [REG_ADDR_W-1:0]  lk,
        input wb_bundle_t [DEPTH-1:0] ent,
        input logic [PW-1:0]          rd,
        input logic [PW:0]            cnt,
        input wb_bundle_t             outs
    );
        logic [DATA_W:0] res;
        wb_bundle_t      e;
        res = '0;
        e   = outs;
        if (e.we1 && e.reg1 == lk) res = {1'b1, e.data1};
        if (e.we2 && e.reg2 == lk) res = {1'b1, e.data2};
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(cnt)) begin
                e = ent[rd + PW'(k)];
                if (e.we1 && e.reg1 == lk) res = {1'b1, e.data1};
                if (e.we2 && e.reg2 == lk) res = {1'b1, e.data2};
            end
        end
        if (ZERO_REG && lk == '0) res = '0;
        return res;
    endfunction

    assign {Hit1, HitData1} = f_lookup(LookupReg1, w_entries, w_rd_ptr, Count, w_outs);
    assign {Hit2, HitData2} = f_lookup(LookupReg2, w_entries, w_rd_ptr, Count, w_outs);

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed plus random bench for regfile_write_buffer against a queue-based
// model of the write-back staging rules.
module tb_regfile_write_buffer;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        InValid = 1'b0, InWe1 = 1'b0, InWe2 = 1'b0, Stall = 1'b0;
    logic [4:0]  InReg1 = '0, InReg2 = '0, LookupReg1 = '0, LookupReg2 = '0;
    logic [31:0] InData1 = '0, InData2 = '0;
    logic        InReady, RegWrite1, RegWrite2, Hit1, Hit2;
    logic [4:0]  WriteRegister1, WriteRegister2;
    logic [31:0] WriteData1, WriteData2, HitData1, HitData2;
    logic [2:0]  Count;
    logic [7:0]  CollisionCount;

    regfile_write_buffer #(.DEPTH(DEPTH), .ZERO_REG(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InWe1(InWe1), .InWe2(InWe2), .InReg1(InReg1), .InReg2(InReg2),
        .InData1(InData1), .InData2(InData2), .Stall(Stall),
        .WriteRegister1(WriteRegister1), .WriteRegister2(WriteRegister2),
        .WriteData1(WriteData1), .WriteData2(WriteData2),
        .RegWrite1(RegWrite1), .RegWrite2(RegWrite2),
        .LookupReg1(LookupReg1), .LookupReg2(LookupReg2),
        .Hit1(Hit1), .Hit2(Hit2), .HitData1(HitData1), .HitData2(HitData2),
        .Count(Count), .CollisionCount(CollisionCount)
    );

    always #5 Clk = ~Clk;

    int         n_vec = 0;
    int         n_err = 0;
    wb_bundle_t q[$];
    wb_bundle_t mout = '0;
    int         mcc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic wb_bundle_t mk(input bit w1, input int r1, input logic [31:0] d1,
                                      input bit w2, input int r2, input logic [31:0] d2);
        wb_bundle_t b;
        b.we1 = w1; b.reg1 = r1[4:0]; b.data1 = d1;
        b.we2 = w2; b.reg2 = r2[4:0]; b.data2 = d2;
        return b;
    endfunction

    // Stored form of an accepted bundle; also bumps the model collision count
    function automatic wb_bundle_t mnorm(input wb_bundle_t b);
        wb_bundle_t n = b;
        if (n.reg1 == 0) n.we1 = 1'b0;
        if (n.reg2 == 0) n.we2 = 1'b0;
        if (n.we1 && n.we2 && n.reg1 == n.reg2) begin
            n.we1 = 1'b0;
            if (mcc < 255) mcc++;
        end
        return n;
    endfunction

    // Newest first, lane 2 before lane 1, output stage last
    function automatic logic [32:0] mlook(input logic [4:0] r);
        if (r == 0) return '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].we2 && q[i].reg2 == r) return {1'b1, q[i].data2};
            if (q[i].we1 && q[i].reg1 == r) return {1'b1, q[i].data1};
        end
        if (mout.we2 && mout.reg2 == r) return {1'b1, mout.data2};
        if (mout.we1 && mout.reg1 == r) return {1'b1, mout.data1};
        return '0;
    endfunction

    task automatic chk_outputs();
        chk("count", Count, q.size());
        chk("regwrite1", RegWrite1, mout.we1);
        chk("regwrite2", RegWrite2, mout.we2);
        chk("writereg1", WriteRegister1, mout.reg1);
        chk("writereg2", WriteRegister2, mout.reg2);
        chk("writedata1", WriteData1, mout.data1);
        chk("writedata2", WriteData2, mout.data2);
        chk("collcount", CollisionCount, mcc);
    endtask

    task automatic step(input bit v, input wb_bundle_t b, input bit st,
                        input int l1, input int l2);
        logic [32:0] e1, e2;
        bit pop, push;
        @(negedge Clk);
        InValid = v; Stall = st;
        InWe1 = b.we1; InReg1 = b.reg1; InData1 = b.data1;
        InWe2 = b.we2; InReg2 = b.reg2; InData2 = b.data2;
        LookupReg1 = l1[4:0]; LookupReg2 = l2[4:0];
        #1;
        chk("inready", InReady, q.size() != DEPTH);
        e1 = mlook(l1[4:0]);
        e2 = mlook(l2[4:0]);
        chk("hit1", Hit1, e1[32]);
        chk("hitdata1", HitData1, e1[31:0]);
        chk("hit2", Hit2, e2[32]);
        chk("hitdata2", HitData2, e2[31:0]);
        pop  = (q.size() != 0) && !st;
        push = v && (q.size() != DEPTH);
        @(posedge Clk);
        if (pop) mout = q.pop_front();
        else begin mout.we1 = 1'b0; mout.we2 = 1'b0; end
        if (push) q.push_back(mnorm(b));
        #1;
        chk_outputs();
    endtask

    task automatic idle(input bit st, input int l1, input int l2);
        step(1'b0, '0, st, l1, l2);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_count", Count, 0);
        chk("rst_regwrite", {RegWrite1, RegWrite2}, 0);
        chk("rst_inready", InReady, 1);
        chk("rst_collcount", CollisionCount, 0);
        chk("rst_writereg", {WriteRegister1, WriteRegister2, WriteData1, WriteData2}, 0);
        @(negedge Clk);
        Reset = 1'b0;

        // single write: visible one edge after acceptance, for one cycle
        step(1, mk(1, 3, 32'hA5A5A5A5, 0, 0, 0), 0, 3, 0);
        idle(0, 3, 0);
        chk("single_we1", RegWrite1, 1);
        chk("single_reg1", WriteRegister1, 3);
        chk("single_data1", WriteData1, 32'hA5A5A5A5);
        chk("single_we2", RegWrite2, 0);
        idle(0, 3, 0);
        chk("single_we1_off", RegWrite1, 0);

        // same-register collision: lane 2 wins
        step(1, mk(1, 1, 32'h11, 1, 1, 32'h22), 0, 1, 0);
        chk("coll_count", CollisionCount, 1);
        idle(0, 1, 1);
        chk("coll_we1", RegWrite1, 0);
        chk("coll_we2", RegWrite2, 1);
        chk("coll_data2", WriteData2, 32'h22);
        idle(0, 0, 1);

        // register 0 dropped and never hits
        step(1, mk(1, 0, 32'hDEAD, 1, 5, 32'h55), 0, 0, 5);
        idle(0, 0, 5);
        chk("zero_we1", RegWrite1, 0);
        chk("zero_we2", RegWrite2, 1);
        chk("zero_hit", Hit1, 0);
        idle(0, 0, 5);

        // fill under stall, fifth bundle waits, then in-order drain
        for (int i = 0; i < 4; i++) step(1, mk(1, 8 + i, 32'h100 + i, 0, 0, 0), 1, 8, 11);
        step(1, mk(1, 12, 32'h104, 0, 0, 0), 1, 9, 12);
        chk("full_inready", InReady, 0);
        chk("full_count", Count, 4);
        for (int i = 0; i < 4; i++) begin
            idle(0, 8 + i, 10);
            chk("drain_order", {RegWrite1, WriteRegister1}, {1'b1, 5'(8 + i)});
        end
        idle(0, 11, 0);

        // bypass ordering: newer reg 7 write shadows the older one
        step(1, mk(1, 7, 32'h1, 0, 0, 0), 1, 7, 0);
        step(1, mk(1, 7, 32'h2, 0, 0, 0), 1, 7, 0);
        idle(1, 7, 0);
        chk("bypass_newest", {Hit1, HitData1}, {1'b1, 32'h2});
        for (int i = 0; i < 3; i++) idle(0, 7, 7);
        chk("bypass_gone", Hit1, 0);

        // async reset with queued bundles
        for (int i = 0; i < 3; i++) step(1, mk(1, 20 + i, 32'h200 + i, 1, 24 + i, 32'h300 + i), 1, 21, 25);
        @(negedge Clk);
        InValid = 1'b0;
        Reset = 1'b1;
        #1;
        chk("mid_rst_count", Count, 0);
        chk("mid_rst_regwrite", {RegWrite1, RegWrite2}, 0);
        q.delete();
        mout = '0;
        mcc = 0;
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) idle(0, 21, 25);

        // random traffic with a small register pool to provoke collisions and hits
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0,
                 mk($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 7), $urandom),
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 7), $urandom_range(0, 7));
        end
        for (int i = 0; i < 6; i++) idle(0, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
